pe_operand_feeder: RTL
======================

Name: pe_operand_feeder

Overview:
- Upstream stage of processing_element. Buffers a stream of signed-agnostic operand pairs in a small FIFO and issues them one at a time to the PE using its start/ready/ack handshake.
- On the element flagged "last", captures the PE accumulator (s_out) into a result register and presents it on a valid/ready output stream.
- After capture, pulses the PE clear line so the next vector accumulates from zero.

Parameters:
- PRECISION, 8, operand width (matches PE PRECISION).
- OUTPUT_PRECISION, 32, accumulator/result width (matches PE OUTPUT_PRECISION).
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- CNT_W, 16, width of element counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept (= !full).
- in_a  in  PRECISION  operand A.
- in_b  in  PRECISION  operand B.
- in_last  in  1  pair is final element of a vector.
- pe_a  out  PRECISION  to PE a_in.
- pe_b  out  PRECISION  to PE b_in.
- pe_start  out  1  to PE start_multiply.
- pe_ready  in  1  from PE pe_ready.
- pe_ack  out  1  to PE pe_ack.
- pe_clear  out  1  to PE reset (active-high accumulator clear).
- pe_result  in  OUTPUT_PRECISION  from PE s_out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUTPUT_PRECISION  captured accumulator.
- out_count  out  CNT_W  number of elements in the vector (saturating).

Behaviour:
- Reset: FIFO empty, in_ready=1, pe_start=0, pe_ack=0, pe_clear=0, out_valid=0, pe_a/pe_b/out_data/out_count=0, FSM=IDLE, counter=0.
- FIFO: push on in_valid&&in_ready; pop only on FSM IDLE→ISSUE. Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits. in_ready registered from next occupancy, so a push and pop in the same cycle when full is not possible (full ⇒ in_ready=0). Data is never dropped or duplicated.
- FSM (one-hot or encoded, registered outputs):
  - IDLE: if FIFO not empty and pe_ready=1, pop head into pe_a/pe_b/last_q, set pe_start=1 → ISSUE.
  - ISSUE: hold pe_start and operands stable until pe_ready=0 (PE accepted); then pe_start=0 → BUSY.
  - BUSY: wait for pe_ready=1; increment counter (saturate at all-ones) → ACK.
  - ACK: pe_ack=1 for exactly one cycle. If last_q, capture pe_result→out_data, counter→out_count, out_valid=1 → EMIT; else → IDLE.
  - EMIT: hold out_valid/out_data/out_count until out_ready=1; then out_valid=0, pe_clear=1, counter=0 → CLEAR.
  - CLEAR: pe_clear held one cycle, then 0; wait pe_ready=1 → IDLE.
- Latency: a pair pushed into an empty FIFO with the PE idle drives pe_start two cycles after the push edge (one for FIFO write, one for the pop/issue register).
- Upstream pushes continue during BUSY/ACK/EMIT/CLEAR until full.
- out_valid, once high, drops only on the out_ready handshake.
- Result capture occurs only in ACK, never while PE busy.
- in_last on a vector of one element is legal: count=1.
- reset_n assertion mid-operation: all state returns to reset values immediately (async). The PE is reset separately by the system; the feeder does not pulse pe_clear on reset.

Decomposition:
- Shared package pe_pkg: FSM state enum (IDLE, ISSUE, BUSY, ACK, EMIT, CLEAR), default PRECISION/OUTPUT_PRECISION constants reused by processing_element.
- One sub-module: pe_operand_fifo (parameterised sync FIFO, width 2*PRECISION+1, DEPTH, flags full/empty). FSM and result register live in the top.

Test Plan:
- Single vector of one element: push a=0x3D, b=0x71, last=1 -> pe_start seen, out_valid with out_data=6893, out_count=1, then one-cycle pe_clear.
- Two-element vector: push (0x3D,0x71,0),(0x3D,0x71,1) -> exactly two start/ack cycles, out_data=13786, out_count=2.
- FIFO full: hold PE busy (pe_ready=0), push 5 pairs with DEPTH=4 -> in_ready=0 after 4th accepted, 5th stalled; all 5 later issued in order.
- Output backpressure: out_ready=0 for 10 cycles after result -> out_valid/out_data stable, no pe_clear, no new pe_start until out_ready=1.
- Async reset mid-BUSY: drop reset_n between clock edges -> all outputs zero immediately, FIFO empty, in_ready=1. After release, a fresh vector (2,3,last) yields 6 when the PE was reset externally.
- Back-to-back vectors: (1,1,1),(2,2,1) pushed consecutively -> results 1 then 4 (clear between), out_count=1 each.

Source files
------------

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing element and its operand feeder.
//   - Default operand / accumulator widths, so the PE and the feeder agree.
//   - Default feeder FIFO depth and element-counter width.
//   - Feeder FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_PRECISION        = 8;
  localparam int PE_OUTPUT_PRECISION = 32;
  localparam int FEEDER_DEPTH        = 4;
  localparam int FEEDER_CNT_W        = 16;

  // Feeder sequencing states: issue one operand pair to the PE, wait for it
  // to finish, acknowledge, and on the last element emit and clear.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    ACK   = 3'd3,
    EMIT  = 3'd4,
    CLEAR = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/pe_operand_feeder_if.sv
// ---------------------------------------------------------------------------
// pe_operand_feeder_if
// Bundles the three streams around the operand feeder:
//   - operand input stream : in_valid/in_ready/in_a/in_b/in_last
//   - PE handshake         : pe_a/pe_b/pe_start/pe_ready/pe_ack/pe_clear/pe_result
//   - result output stream : out_valid/out_ready/out_data/out_count
// Modports:
//   slave  - the feeder's view (drives in_ready, PE controls and results)
//   master - the surrounding system's view (producer, PE and consumer)
// ---------------------------------------------------------------------------
interface pe_operand_feeder_if
  import pe_pkg::*;
#(
  parameter int PRECISION        = PE_PRECISION,
  parameter int OUTPUT_PRECISION = PE_OUTPUT_PRECISION,
  parameter int CNT_W            = FEEDER_CNT_W
);

  logic                        in_valid;
  logic                        in_ready;
  logic [PRECISION-1:0]        in_a;
  logic [PRECISION-1:0]        in_b;
  logic                        in_last;

  logic [PRECISION-1:0]        pe_a;
  logic [PRECISION-1:0]        pe_b;
  logic                        pe_start;
  logic                        pe_ready;
  logic                        pe_ack;
  logic                        pe_clear;
  logic [OUTPUT_PRECISION-1:0] pe_result;

  logic                        out_valid;
  logic                        out_ready;
  logic [OUTPUT_PRECISION-1:0] out_data;
  logic [CNT_W-1:0]            out_count;

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    output in_ready,
    output pe_a, pe_b, pe_start, pe_ack, pe_clear,
    input  pe_ready, pe_result,
    output out_valid, out_data, out_count,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_last,
    input  in_ready,
    input  pe_a, pe_b, pe_start, pe_ack, pe_clear,
    output pe_ready, pe_result,
    input  out_valid, out_data, out_count,
    output out_ready
  );

endinterface

// File: rtl/pe_operand_fifo.sv
// ---------------------------------------------------------------------------
// pe_operand_fifo
// Small synchronous FIFO holding packed operand entries {last, a, b}.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write request / data (ignored while full)
//   pop, rdata   - read request (ignored while empty) / head entry
//   full, empty  - registered status flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module pe_operand_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy; the flags are registered from it so that full/empty
  // are glitch-free outputs that change only on the clock edge.
  always_comb begin
    occ_next = occ;
    case ({do_push, do_pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      occ   <= occ_next;
      full  <= (occ_next == OCC_W'(DEPTH));
      empty <= (occ_next == '0);
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pe_operand_feeder.sv
// ---------------------------------------------------------------------------
// pe_operand_feeder
// Buffers operand pairs and feeds them one at a time to the processing
// element; on the element marked last it captures the PE accumulator,
// presents it on a valid/ready result stream, then pulses the PE clear.
// Ports:
//   CLK      - system clock (rising edge)
//   reset_n  - asynchronous active-low reset
//   bus      - pe_operand_feeder_if.slave: operand input stream, PE
//              handshake and result output stream
// ---------------------------------------------------------------------------
module pe_operand_feeder
  import pe_pkg::*;
#(
  parameter int PRECISION        = PE_PRECISION,
  parameter int OUTPUT_PRECISION = PE_OUTPUT_PRECISION,
  parameter int DEPTH            = FEEDER_DEPTH,
  parameter int CNT_W            = FEEDER_CNT_W
) (
  input logic               CLK,
  input logic               reset_n,
  pe_operand_feeder_if.slave bus
);

  localparam int ENTRY_W = 2 * PRECISION + 1;

  logic [ENTRY_W-1:0]          fifo_wdata;
  logic [ENTRY_W-1:0]          fifo_rdata;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;

  logic                        head_last;
  logic [PRECISION-1:0]        head_a;
  logic [PRECISION-1:0]        head_b;

  feeder_state_e               state_q,     state_d;
  logic [PRECISION-1:0]        pe_a_q,      pe_a_d;
  logic [PRECISION-1:0]        pe_b_q,      pe_b_d;
  logic                        last_q,      last_d;
  logic                        start_q,     start_d;
  logic                        ack_q,       ack_d;
  logic                        clear_q,     clear_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUTPUT_PRECISION-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]            out_count_q, out_count_d;
  logic [CNT_W-1:0]            cnt_q,       cnt_d;

  // Entries are packed {last, a, b}; in_ready is simply the registered
  // not-full flag, so a push can never land on a full FIFO.
  assign fifo_wdata = {bus.in_last, bus.in_a, bus.in_b};
  assign fifo_push  = bus.in_valid && bus.in_ready;
  assign head_last  = fifo_rdata[ENTRY_W-1];
  assign head_a     = fifo_rdata[2*PRECISION-1:PRECISION];
  assign head_b     = fifo_rdata[PRECISION-1:0];

  pe_operand_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and next-output logic. All PE and result outputs are
  // registered; ack and clear default low so each is a one-cycle pulse
  // that is only raised on entry to ACK / CLEAR.
  always_comb begin
    state_d     = state_q;
    pe_a_d      = pe_a_q;
    pe_b_d      = pe_b_q;
    last_d      = last_q;
    start_d     = start_q;
    ack_d       = 1'b0;
    clear_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.pe_ready) begin
          fifo_pop = 1'b1;
          pe_a_d   = head_a;
          pe_b_d   = head_b;
          last_d   = head_last;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The PE drops ready once it has latched the operands.
        if (!bus.pe_ready) begin
          start_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.pe_ready) begin
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // The accumulator is sampled here, after the PE reported done.
        if (last_q) begin
          out_data_d  = bus.pe_result;
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          clear_d     = 1'b1;
          cnt_d       = '0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        if (bus.pe_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle without
  // touching the PE clear line (the PE has its own system reset).
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      last_q      <= 1'b0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      clear_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      last_q      <= last_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      clear_q     <= clear_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.pe_a      = pe_a_q;
  assign bus.pe_b      = pe_b_q;
  assign bus.pe_start  = start_q;
  assign bus.pe_ack    = ack_q;
  assign bus.pe_clear  = clear_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule
